dmem_line_responder: RTL and testbench

//  Responder end of the data-cache <-> data-memory line interface. Accepts one 256-bit line read or write
//  per request from the dcache controller, services it after a fixed programmable latency, and returns a

---
 rtl/dmem_line_responder.sv | 126 ++++++++++++
 tb/tb_dmem_line_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: responder end of the dcache <-> data-memory line
// interface. Each accepted request is serviced after LATENCY cycles and
// answered with a one-cycle ack, then one dead turnaround cycle follows.
// Optional feature macro: DMEM_STATS_EN adds completed read/write counters.
module dmem_line_responder #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
`ifdef DMEM_STATS_EN
  output logic [31:0]  rd_count_o,
  output logic [31:0]  wr_count_o,
`endif
  output logic [255:0] data_o
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK, S_TURN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, enter_ack;
  logic               req_wr_q;
  logic [IDX_W-1:0]   req_idx_q;
  logic [255:0]       req_data_q;
  logic               op_wr;
  logic [IDX_W-1:0]   op_idx;
  logic [255:0]       op_data;
  logic               ack_q;
  logic               unused_addr;

  logic [255:0] mem [DEPTH];

  assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  // With LATENCY==1 the ACK-entry edge is the acceptance edge, so the
  // operation has to come straight from the inputs rather than the latches.
  assign op_wr   = (state_q == S_IDLE) ? write_i : req_wr_q;
  assign op_idx  = (state_q == S_IDLE) ? addr_i[5+IDX_W-1:5] : req_idx_q;
  assign op_data = (state_q == S_IDLE) ? data_i : req_data_q;

  // Next-state, latency countdown and ACK-entry decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    enter_ack = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d   = S_ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d   = S_ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK:   state_d = S_TURN;
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, request latches, registered ack and read data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_wr_q   <= 1'b0;
      req_idx_q  <= '0;
      req_data_q <= '0;
      ack_q      <= 1'b0;
      data_o     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_ack;
      if (accept) begin
        req_wr_q   <= write_i;
        req_idx_q  <= addr_i[5+IDX_W-1:5];
        req_data_q <= data_i;
      end
      if (enter_ack && !op_wr) data_o <= mem[op_idx];
    end
  end

  // Line array write at ACK entry; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (rst_i && enter_ack && op_wr) mem[op_idx] <= op_data;
  end

  assign ack_o = ack_q;

`ifdef DMEM_STATS_EN
  // Saturating completion counters, bumped at ACK entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if (enter_ack) begin
      if (!op_wr && rd_count_o != '1) rd_count_o <= rd_count_o + 32'd1;
      if (op_wr && wr_count_o != '1)  wr_count_o <= wr_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_line_responder.sv
module tb_dmem_line_responder;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         en0 = 1'b0, en1 = 1'b0;
  logic         write_s = 1'b0;
  logic [31:0]  addr_s = '0;
  logic [255:0] data_s = '0;
  logic         ack0, ack1;
  logic [255:0] dout0, dout1;
`ifdef DMEM_STATS_EN
  logic [31:0]  rdc0, wrc0, rdc1, wrc1;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [255:0] mdl_mem [2][512];
  logic [255:0] mdl_dout [2];
  int           mdl_rd [2];
  int           mdl_wr [2];
  int           known [$];
  logic         ack0_prev = 1'b0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  dmem_line_responder #(.LATENCY(10), .DEPTH(512), .IDX_W(9)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(en0), .write_i(write_s),
    .addr_i(addr_s), .data_i(data_s), .ack_o(ack0),
`ifdef DMEM_STATS_EN
    .rd_count_o(rdc0), .wr_count_o(wrc0),
`endif
    .data_o(dout0));

  dmem_line_responder #(.LATENCY(1), .DEPTH(512), .IDX_W(9)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(en1), .write_i(write_s),
    .addr_i(addr_s), .data_i(data_s), .ack_o(ack1),
`ifdef DMEM_STATS_EN
    .rd_count_o(rdc1), .wr_count_o(wrc1),
`endif
    .data_o(dout1));

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int unsigned i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic txn(input int sel, input bit wr, input logic [31:0] addr,
                     input logic [255:0] data, input bit drop_early, input bit keep,
                     input bit nwr, input logic [31:0] naddr, input logic [255:0] ndata,
                     output int ack_cyc);
    int L;
    int idx;
    logic a;
    logic [255:0] d;
    L = (sel == 1) ? 1 : 10;
    idx = int'(addr[13:5]);
    ack_cyc = -1;
    write_s = wr; addr_s = addr; data_s = data;
    if (sel == 1) en1 = 1'b1; else en0 = 1'b1;
    @(posedge clk_i); #1;
    for (int k = 0; k <= L; k++) begin
      if (k > 0) begin @(posedge clk_i); #1; end
      if (k == 0 && drop_early) begin
        if (sel == 1) en1 = 1'b0; else en0 = 1'b0;
      end
      a = (sel == 1) ? ack1 : ack0;
      checks++;
      if (a !== (k == L - 1)) begin
        fails++;
        $display("FAIL ack_timing: sel=%0d k=%0d ack=%b required=%b", sel, k, a, (k == L - 1));
      end
      if (k == L - 1) begin
        ack_cyc = cyc;
        if (wr) begin
          mdl_mem[sel][idx] = data;
          mdl_wr[sel]++;
        end else begin
          mdl_dout[sel] = mdl_mem[sel][idx];
          mdl_rd[sel]++;
        end
        d = (sel == 1) ? dout1 : dout0;
        checks++;
        if (d !== mdl_dout[sel]) begin
          fails++;
          $display("FAIL data_at_ack: sel=%0d idx=%0d got=%h required=%h", sel, idx, d, mdl_dout[sel]);
        end
      end
    end
    if (keep) begin
      write_s = nwr; addr_s = naddr; data_s = ndata;
    end else begin
      if (sel == 1) en1 = 1'b0; else en0 = 1'b0;
    end
    @(posedge clk_i); #1;
    a = (sel == 1) ? ack1 : ack0;
    d = (sel == 1) ? dout1 : dout0;
    checks++;
    if (a !== 1'b0 || d !== mdl_dout[sel]) begin
      fails++;
      $display("FAIL turnaround: sel=%0d ack=%b data=%h required ack=0 data=%h", sel, a, d, mdl_dout[sel]);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef DMEM_STATS_EN
    checks++;
    if (rdc0 !== 32'(mdl_rd[0]) || wrc0 !== 32'(mdl_wr[0]) ||
        rdc1 !== 32'(mdl_rd[1]) || wrc1 !== 32'(mdl_wr[1])) begin
      fails++;
      $display("FAIL stats_%s: got rd0=%0d wr0=%0d rd1=%0d wr1=%0d required %0d %0d %0d %0d",
               tag, rdc0, wrc0, rdc1, wrc1, mdl_rd[0], mdl_wr[0], mdl_rd[1], mdl_wr[1]);
    end
`else
    checks++;
    if (tag.len() == 0) begin
      fails++;
      $display("FAIL stats: empty tag");
    end
`endif
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0 || dout0 !== '0 || dout1 !== '0) begin
      fails++;
      $display("FAIL reset_state: ack0=%b ack1=%b dout0=%h dout1=%h required 0", ack0, ack1, dout0, dout1);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (ack0 !== 1'b0 || dout0 !== '0) begin
      fails++;
      $display("FAIL reset_release: ack0=%b dout0=%h required 0", ack0, dout0);
    end
    check_stats("reset");
  endtask

  task automatic test_read_latency();
    int c;
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    txn(0, 1'b1, 32'h0000_0060, a5, 1'b0, 1'b0, 1'b0, '0, '0, c);
    known.push_back(3);
    txn(0, 1'b0, 32'h0000_0060, '0, 1'b0, 1'b0, 1'b0, '0, '0, c);
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (dout0 !== a5) begin
      fails++;
      $display("FAIL read_hold: got=%h required=%h", dout0, a5);
    end
  endtask

  task automatic test_write_alias();
    int c;
    txn(0, 1'b1, 32'h0000_0480, 256'h1234, 1'b0, 1'b0, 1'b0, '0, '0, c);
    known.push_back(36);
    txn(0, 1'b0, 32'h0000_0480, '0, 1'b0, 1'b0, 1'b0, '0, '0, c);
    checks++;
    if (dout0 !== 256'h1234) begin
      fails++;
      $display("FAIL write_read: got=%h required=1234", dout0);
    end
    txn(0, 1'b0, 32'h0004_0480, '0, 1'b0, 1'b0, 1'b0, '0, '0, c);
    checks++;
    if (dout0 !== 256'h1234) begin
      fails++;
      $display("FAIL alias_read: got=%h required=1234", dout0);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2, c3;
    logic [255:0] l5, l7;
    l5 = rand_line(); l7 = rand_line();
    txn(0, 1'b1, 32'h0000_00E0, l7, 1'b0, 1'b0, 1'b0, '0, '0, c1);
    known.push_back(7);
    txn(0, 1'b1, 32'h0000_00A0, l5, 1'b0, 1'b1, 1'b0, 32'h0000_00E0, '0, c1);
    known.push_back(5);
    txn(0, 1'b0, 32'h0000_00E0, '0, 1'b0, 1'b0, 1'b0, '0, '0, c2);
    checks++;
    if (c2 - c1 !== 12) begin
      fails++;
      $display("FAIL b2b_spacing: got=%0d required=12", c2 - c1);
    end
    checks++;
    if (dout0 !== l7) begin
      fails++;
      $display("FAIL b2b_refill: got=%h required=%h", dout0, l7);
    end
    txn(0, 1'b0, 32'h0000_00A0, '0, 1'b0, 1'b0, 1'b0, '0, '0, c3);
    checks++;
    if (dout0 !== l5) begin
      fails++;
      $display("FAIL b2b_writeback: got=%h required=%h", dout0, l5);
    end
  endtask

  task automatic test_latency1();
    int c1, c2;
    logic [255:0] l2;
    l2 = rand_line();
    txn(1, 1'b1, 32'h0000_0040, l2, 1'b0, 1'b1, 1'b0, 32'h0000_0040, '0, c1);
    txn(1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0, 1'b0, '0, '0, c2);
    checks++;
    if (c2 - c1 !== 3) begin
      fails++;
      $display("FAIL lat1_spacing: got=%0d required=3", c2 - c1);
    end
    checks++;
    if (dout1 !== l2) begin
      fails++;
      $display("FAIL lat1_read: got=%h required=%h", dout1, l2);
    end
  endtask

  task automatic test_reset_midflight();
    int c;
    logic [255:0] v1, v2;
    v1 = rand_line(); v2 = rand_line();
    txn(0, 1'b1, 32'h0000_0120, v1, 1'b0, 1'b0, 1'b0, '0, '0, c);
    known.push_back(9);
    write_s = 1'b1; addr_s = 32'h0000_0120; data_s = v2; en0 = 1'b1;
    @(posedge clk_i); #1;
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    mdl_dout[0] = '0; mdl_dout[1] = '0;
    mdl_rd[0] = 0; mdl_wr[0] = 0; mdl_rd[1] = 0; mdl_wr[1] = 0;
    checks++;
    if (ack0 !== 1'b0 || dout0 !== '0 || dout1 !== '0) begin
      fails++;
      $display("FAIL reset_mid: ack0=%b dout0=%h dout1=%h required 0", ack0, dout0, dout1);
    end
    check_stats("midreset");
    en0 = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_i); #1;
      checks++;
      if (ack0 !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_ack: k=%0d ack=%b required=0", k, ack0);
      end
    end
    txn(0, 1'b0, 32'h0000_0120, '0, 1'b0, 1'b0, 1'b0, '0, '0, c);
    checks++;
    if (dout0 !== v1) begin
      fails++;
      $display("FAIL reset_no_write: got=%h required=%h", dout0, v1);
    end
  endtask

  task automatic test_random();
    int c;
    for (int unsigned n = 0; n < 24; n++) begin
      bit wr;
      int idx;
      logic [31:0] addr;
      wr = ($urandom_range(0, 1) == 1);
      if (wr) idx = int'($urandom_range(0, 511));
      else    idx = known[$urandom_range(0, known.size() - 1)];
      addr = ($urandom() & 32'hFFFF_C000) | (32'(idx) << 5) | ($urandom() & 32'h1F);
      txn(0, wr, addr, rand_line(), ($urandom_range(0, 3) == 0), 1'b0, 1'b0, '0, '0, c);
      if (wr) known.push_back(idx);
    end
    check_stats("random");
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_alias();
    test_back_to_back();
    test_latency1();
    check_stats("directed");
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  always @(posedge clk_i) begin
    if (ack0 === 1'b1 && ack0_prev === 1'b1) begin
      fails++;
      $display("FAIL ack_consecutive: ack0 high two cycles");
    end
    ack0_prev <= ack0;
  end

endmodule
